// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: RV32I load/store opcodes, funct3 codes, fault codes and LSU states
package load_store_unit_pkg;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_ILLEGAL  = 2'b10;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} state_t;
  function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
    return store ? (f3 > F3_W) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
  endfunction
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && |a);
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store byte-lane placement and load extraction/extension
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);
  logic [31:0] sh;
  always_comb begin
    wstrb = funct3[1:0] == 2'b00 ? 4'b0001 << offset : funct3[1:0] == 2'b01 ? 4'b0011 << offset : 4'b1111;
    wdata = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} : funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
    sh = rdata >> {offset, 3'b000};
    load_data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                funct3 == F3_BU ? {24'd0, sh[7:0]} :
                funct3 == F3_HU ? {16'd0, sh[15:0]} : rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage with valid/ready bus, stall, and fault reporting
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic [1:0]  fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  a_q;
  logic [7:0]  cnt;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic        is_ld, is_st;
  logic [3:0]  wstrb;
  logic [31:0] wdata, ext;
  // While idle the aligner sees the live request; afterwards it sees the latched access
  always_comb begin
    f3 = state == S_IDLE ? funct3 : f3_q;
    off = state == S_IDLE ? addr[1:0] : a_q;
    is_ld = opcode == OP_LOAD;
    is_st = opcode == OP_STORE;
    stall = req_valid & ~done;
  end
  lsu_lane_align u_align (
    .funct3(f3), .offset(off), .store_data(store_data), .rdata(mem_rdata),
    .wstrb(wstrb), .wdata(wdata), .load_data(ext)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      done <= 1'b0;
      fault <= FLT_NONE;
      load_data <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      f3_q <= '0;
      a_q <= '0;
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid && (is_ld || is_st)) begin
          f3_q <= funct3;
          a_q <= addr[1:0];
          if (f3_illegal(is_st, funct3) || misaligned(funct3, addr[1:0])) begin
            state <= S_FAULT;
            done <= 1'b1;
            fault <= f3_illegal(is_st, funct3) ? FLT_ILLEGAL : FLT_MISALIGN;
          end else begin
            state <= S_REQ;
            mem_req <= 1'b1;
            mem_we <= is_st;
            mem_addr <= {addr[31:2], 2'b00};
            mem_wstrb <= is_st ? wstrb : 4'b0000;
            mem_wdata <= is_st ? wdata : 32'd0;
            cnt <= '0;
          end
        end
        S_REQ: if (mem_ready || cnt == 8'(TIMEOUT_CYCLES - 1)) begin
          state <= S_DONE;
          done <= 1'b1;
          mem_req <= 1'b0;
          mem_we <= 1'b0;
          fault <= mem_ready ? FLT_NONE : FLT_TIMEOUT;
          load_data <= mem_ready && !mem_we ? ext : 32'd0;
        end else cnt <= cnt + 8'd1;
        S_DONE, S_FAULT: begin
          state <= S_IDLE;
          done <= 1'b0;
          fault <= FLT_NONE;
          load_data <= '0;
        end
      endcase
    end
  end
endmodule
